// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Register sets are sized for the largest supported display; narrower
// instances zero-fill the unused upper digits.
package sevenseg_pkg;

  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned IDX_W      = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // One complete display image: value nibbles, dp requests, enables, lzb mode.
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] value;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   en;
    logic                    lzb;
  } disp_set_t;

  // Hex glyphs as active-low {CA,CB,CC,CD,CE,CF,CG}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_timebase.sv
// Digit-slot timebase: cycle counter within a slot, digit index, frame wrap
// and (when SEVENSEG_PWM_EN is defined) a free-running brightness PWM.
module sevenseg_timebase
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 6250,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                cnt_ge_blank_o,
  output logic                frame_wrap_o,
  output logic                pwm_on_o
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cnt_wrap;
  logic             idx_last;

  assign cnt_wrap = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Next slot position: cnt wraps each slot, idx advances at every cnt wrap.
  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Slot position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o          = idx_q;
  assign cnt_ge_blank_o = (cnt_q >= CNT_W'(BLANK_CYCLES));
  assign frame_wrap_o   = cnt_wrap & idx_last;

`ifdef SEVENSEG_PWM_EN
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + BRIGHT_W'(1);

  // Free-running PWM phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_on_o = (pwm_q <= bright_i);
`else
  logic unused_bright;

  assign unused_bright = ^bright_i;
  assign pwm_on_o      = 1'b1;
`endif

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment controller: common-anode strobes and
// active-low cathodes, frame-synchronous double-buffered loading, per-digit
// enables, leading-zero blanking and an anti-ghosting guard at slot start.
// Optional brightness PWM is built when SEVENSEG_PWM_EN is defined.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_lzb,
  input  logic [BRIGHT_W-1:0]     i_bright,
  input  logic                    i_load,
  output logic                    o_busy,
  output logic                    o_frame,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp
);

  localparam int unsigned DIGIT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("sevenseg_scan: NUM_DIGITS must be 1..16");
  end
  if (DIGIT_CYCLES < BLANK_CYCLES + 2) begin : g_bad_timing
    $error("sevenseg_scan: digit slot too short for BLANK_CYCLES");
  end

  logic [IDX_W-1:0] idx;
  logic             cnt_ge_blank;
  logic             frame_wrap;
  logic             pwm_on;

  sevenseg_timebase #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BRIGHT_W    (BRIGHT_W)
  ) u_timebase (
    .clk           (clk),
    .rst           (rst),
    .bright_i      (i_bright),
    .idx_o         (idx),
    .cnt_ge_blank_o(cnt_ge_blank),
    .frame_wrap_o  (frame_wrap),
    .pwm_on_o      (pwm_on)
  );

  disp_set_t pend_q, pend_d;
  disp_set_t act_q,  act_d;
  disp_set_t cap;
  logic      busy_q, busy_d;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q;

  // Zero-extend the load inputs into a full-size register set.
  always_comb begin
    cap                           = '0;
    cap.value[4*NUM_DIGITS-1:0]   = i_value;
    cap.dp[NUM_DIGITS-1:0]        = i_dp;
    cap.en[NUM_DIGITS-1:0]        = i_digit_en;
    cap.lzb                       = i_lzb;
  end

  // Double-buffer control: a load at the frame boundary bypasses pending so
  // the newest request always wins and busy never flickers.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    busy_d = busy_q;
    if (frame_wrap) begin
      if (i_load) begin
        act_d  = cap;
        busy_d = 1'b0;
      end else if (busy_q) begin
        act_d  = pend_q;
        busy_d = 1'b0;
      end
    end else if (i_load) begin
      pend_d = cap;
      busy_d = 1'b1;
    end
  end

  logic [MAX_DIGITS-1:0] lzb_blank;
  logic                  zacc;

  // Digit k>0 is blanked when it and every more significant nibble are zero.
  always_comb begin
    zacc      = 1'b1;
    lzb_blank = '0;
    for (int unsigned k = MAX_DIGITS; k > 0; k--) begin
      zacc = zacc & (act_q.value[4*(k-1) +: 4] == 4'h0);
      if (k > 1) begin
        lzb_blank[k-1] = act_q.lzb & zacc;
      end
    end
  end

  logic [3:0] cur_nib;
  logic       cur_show;
  logic       cur_strobe;

  assign cur_nib    = act_q.value[{idx, 2'b00} +: 4];
  assign cur_show   = act_q.en[idx] & ~lzb_blank[idx];
  assign cur_strobe = cur_show & cnt_ge_blank & pwm_on;

  // Output decode for the current slot; anode held off during the guard.
  always_comb begin
    an_d = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = ~(cur_strobe && (idx == IDX_W'(k)));
    end
    seg_d = cur_show ? hex_to_seg(cur_nib) : SEG_BLANK;
    dp_d  = ~(cur_show & act_q.dp[idx]);
  end

  // Register sets, busy flag and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      act_q   <= '0;
      busy_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_wrap;
    end
  end

  assign o_busy  = busy_q;
  assign o_frame = frame_q;
  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;

endmodule
